// File: rtl/avalon_ahb_bridge.sv
// Avalon-MM slave to AHB-Lite master bridge: each Avalon read/write command is
// replayed as one SINGLE NONSEQ AHB transfer, with read data and error status returned.
module avalon_ahb_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic        readdatavalid,
    output logic [31:0] readdata,
    output logic [1:0]  response,
    output logic        bus_error,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        accept;
    logic        complete;
    logic [2:0]  size_dec;
    logic [1:0]  lsb_dec;
    logic [31:0] haddr_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;
    logic [31:0] hwdata_q;

    // Byte lanes select the transfer size and the low address bits; odd patterns fall back to a word.
    always_comb begin
        size_dec = 3'b010;
        lsb_dec  = 2'b00;
        case (byteenable)
            4'b0011: begin size_dec = 3'b001; lsb_dec = 2'b00; end
            4'b1100: begin size_dec = 3'b001; lsb_dec = 2'b10; end
            4'b0001: begin size_dec = 3'b000; lsb_dec = 2'b00; end
            4'b0010: begin size_dec = 3'b000; lsb_dec = 2'b01; end
            4'b0100: begin size_dec = 3'b000; lsb_dec = 2'b10; end
            4'b1000: begin size_dec = 3'b000; lsb_dec = 2'b11; end
            default: begin size_dec = 3'b010; lsb_dec = 2'b00; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (read || write) begin
                    accept  = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (HREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (HREADY) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A simultaneous read+write is treated as a write; the response is sampled only on the HREADY edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            haddr_q       <= 32'h0;
            hwrite_q      <= 1'b0;
            hsize_q       <= 3'b010;
            hwdata_q      <= 32'h0;
            readdatavalid <= 1'b0;
            readdata      <= 32'h0;
            response      <= 2'b00;
            bus_error     <= 1'b0;
        end else begin
            state_q       <= state_d;
            readdatavalid <= 1'b0;
            bus_error     <= 1'b0;
            if (accept) begin
                haddr_q  <= {address[31:2], lsb_dec};
                hwrite_q <= write;
                hsize_q  <= size_dec;
                hwdata_q <= writedata;
            end
            if (complete) begin
                bus_error <= (HRESP == 2'b01);
                if (!hwrite_q) begin
                    readdatavalid <= 1'b1;
                    readdata      <= HRDATA;
                    response      <= (HRESP == 2'b01) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    assign waitrequest = reset || (state_q != IDLE);
    assign HTRANS      = (state_q == ADDR) ? 2'b10 : 2'b00;
    assign HADDR       = haddr_q;
    assign HWRITE      = hwrite_q;
    assign HSIZE       = hsize_q;
    assign HWDATA      = hwdata_q;
    assign HBURST      = 3'b000;
    assign HPROT       = 4'b0011;

endmodule

// File: tb/tb_avalon_ahb_bridge.sv
// Self-checking bench for avalon_ahb_bridge: table-driven Avalon commands against a
// cycle-stepped AHB slave, with a scoreboard queue for read data and error strobes.
module tb_avalon_ahb_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic        readdatavalid;
    logic [31:0] readdata;
    logic [1:0]  response;
    logic        bus_error;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          aw;
        int          dw;
        logic        err;
        logic [31:0] hrdata;
        logic [31:0] exp_haddr;
        logic [2:0]  exp_hsize;
    } vec_t;

    typedef struct {
        logic        rdv;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        berr;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[10];

    avalon_ahb_bridge dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .byteenable(byteenable),
        .waitrequest(waitrequest),
        .readdatavalid(readdatavalid),
        .readdata(readdata),
        .response(response),
        .bus_error(bus_error),
        .HADDR(HADDR),
        .HTRANS(HTRANS),
        .HWRITE(HWRITE),
        .HSIZE(HSIZE),
        .HBURST(HBURST),
        .HPROT(HPROT),
        .HWDATA(HWDATA),
        .HRDATA(HRDATA),
        .HREADY(HREADY),
        .HRESP(HRESP)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every read completion or error strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (readdatavalid || bus_error)) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_strobe: got rdv=%b berr=%b expected none", readdatavalid, bus_error);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                checkOutput("sb_rdv", {31'b0, readdatavalid}, {31'b0, e.rdv});
                checkOutput("sb_berr", {31'b0, bus_error}, {31'b0, e.berr});
                if (e.rdv) begin
                    checkOutput("sb_readdata", readdata, e.rdata);
                    checkOutput("sb_response", {30'b0, response}, {30'b0, e.resp});
                end
            end
        end
    end

    // Drives one command from a negedge in IDLE and plays the AHB slave until the completion cycle.
    task automatic applyStimulus(input vec_t v);
        sb_t  e;
        int   wr_cycles;
        logic exp_rdv;
        logic last;
        exp_rdv = v.rd && !v.wr;
        checkOutput("accept_ready", {31'b0, waitrequest}, 32'd0);
        address    = v.addr;
        read       = v.rd;
        write      = v.wr;
        writedata  = v.wdata;
        byteenable = v.be;
        HREADY     = 1'b1;
        HRESP      = 2'b00;
        HRDATA     = 32'hBAD0BAD0;
        if (exp_rdv || v.err) begin
            e.rdv   = exp_rdv;
            e.rdata = v.hrdata;
            e.resp  = v.err ? 2'b10 : 2'b00;
            e.berr  = v.err;
            sb_q.push_back(e);
        end
        @(negedge clk);
        read       = 1'b0;
        write      = 1'b0;
        address    = 32'hFFFF_FFFF;
        writedata  = 32'h0;
        byteenable = 4'h0;
        wr_cycles  = 0;
        for (int i = 0; i <= v.aw; i++) begin
            HREADY = (i == v.aw);
            checkOutput("htrans_addr", {30'b0, HTRANS}, 32'd2);
            checkOutput("haddr", HADDR, v.exp_haddr);
            checkOutput("hsize", {29'b0, HSIZE}, {29'b0, v.exp_hsize});
            checkOutput("hwrite", {31'b0, HWRITE}, {31'b0, v.wr});
            if (waitrequest) wr_cycles++;
            @(negedge clk);
        end
        for (int i = 0; i <= v.dw; i++) begin
            last   = (i == v.dw);
            HREADY = last;
            HRESP  = (v.err && (last || i == v.dw - 1)) ? 2'b01 : 2'b00;
            HRDATA = last ? v.hrdata : 32'hBAD0BAD0;
            checkOutput("htrans_data", {30'b0, HTRANS}, 32'd0);
            checkOutput("no_early_strobe", {30'b0, readdatavalid, bus_error}, 32'd0);
            if (v.wr) checkOutput("hwdata", HWDATA, v.wdata);
            if (waitrequest) wr_cycles++;
            @(negedge clk);
        end
        HREADY = 1'b1;
        HRESP  = 2'b00;
        HRDATA = 32'hBAD0BAD0;
        checkOutput("wait_cycles", wr_cycles, 2 + v.aw + v.dw);
        checkOutput("rdv_timing", {31'b0, readdatavalid}, {31'b0, exp_rdv});
        checkOutput("berr_timing", {31'b0, bus_error}, {31'b0, v.err});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        //           rd    wr    addr          wdata         be      aw dw err   hrdata        exp_haddr     hsize
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1004, 32'h0,        4'b1111, 0, 0, 1'b0, 32'hDEADBEEF, 32'h0000_1004, 3'b010};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_2000, 32'h12345678, 4'b1111, 0, 2, 1'b0, 32'h0,        32'h0000_2000, 3'b010};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_3000, 32'h00AB0000, 4'b0100, 0, 0, 1'b0, 32'h0,        32'h0000_3002, 3'b000};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_3000, 32'hBEEF0000, 4'b1100, 1, 0, 1'b0, 32'h0,        32'h0000_3002, 3'b001};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_4001, 32'h0,        4'b1111, 0, 1, 1'b1, 32'hCAFEF00D, 32'h0000_4000, 3'b010};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_5000, 32'h0,        4'b0011, 1, 0, 1'b0, 32'h0000ABCD, 32'h0000_5000, 3'b001};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_6008, 32'hA5A5A5A5, 4'b1000, 0, 0, 1'b0, 32'h0,        32'h0000_600B, 3'b000};
        vecs[7] = '{1'b0, 1'b1, 32'h0000_7000, 32'h55AA55AA, 4'b0101, 0, 1, 1'b1, 32'h0,        32'h0000_7000, 3'b010};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_8003, 32'h0,        4'b0010, 2, 1, 1'b0, 32'h01020304, 32'h0000_8001, 3'b000};
        vecs[9] = '{1'b1, 1'b0, 32'h0000_9002, 32'h0,        4'b0000, 0, 0, 1'b0, 32'h89ABCDEF, 32'h0000_9000, 3'b010};

        reset      = 1'b1;
        address    = 32'h0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = 32'h0;
        byteenable = 4'h0;
        HRDATA     = 32'h0;
        HREADY     = 1'b1;
        HRESP      = 2'b00;
        repeat (3) @(negedge clk);

        checkOutput("rst_htrans", {30'b0, HTRANS}, 32'd0);
        checkOutput("rst_haddr", HADDR, 32'd0);
        checkOutput("rst_hwrite", {31'b0, HWRITE}, 32'd0);
        checkOutput("rst_hsize", {29'b0, HSIZE}, 32'd2);
        checkOutput("rst_hwdata", HWDATA, 32'd0);
        checkOutput("rst_rdv", {31'b0, readdatavalid}, 32'd0);
        checkOutput("rst_readdata", readdata, 32'd0);
        checkOutput("rst_response", {30'b0, response}, 32'd0);
        checkOutput("rst_berr", {31'b0, bus_error}, 32'd0);
        checkOutput("rst_wait", {31'b0, waitrequest}, 32'd1);
        checkOutput("hburst", {29'b0, HBURST}, 32'd0);
        checkOutput("hprot", {28'b0, HPROT}, 32'd3);

        reset = 1'b0;
        @(negedge clk);

        // Consecutive calls start in the completion cycle, so back-to-back acceptance is exercised.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset while ADDR is stalled: the aborted read must never complete.
        read       = 1'b1;
        address    = 32'h0000_A000;
        byteenable = 4'b1111;
        @(negedge clk);
        read   = 1'b0;
        HREADY = 1'b0;
        checkOutput("abort_in_addr", {30'b0, HTRANS}, 32'd2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_htrans", {30'b0, HTRANS}, 32'd0);
        checkOutput("abort_wait_hi", {31'b0, waitrequest}, 32'd1);
        @(negedge clk);
        checkOutput("abort_wait_hi2", {31'b0, waitrequest}, 32'd1);
        reset  = 1'b0;
        HREADY = 1'b1;
        #1;
        checkOutput("abort_wait_lo", {31'b0, waitrequest}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("abort_no_rdv", {30'b0, readdatavalid, bus_error}, 32'd0);
            checkOutput("abort_idle", {30'b0, HTRANS}, 32'd0);
        end

        applyStimulus(vecs[0]);
        repeat (2) @(negedge clk);
        checkOutput("sb_drained", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
